instr_mem_loader: RTL

- Writer side of the single-cycle CPU's instruction path: packs symbolic instruction requests (class plus fields) into 32-bit MIPS words and writes them sequentially into instruction memory.
- The main decoder later reads back opcodes R=000000, LW=100011, SW=101011, BEQ=000100 and J=000010.
- Used by the boot/program-load path and by benches to build programs without a hex file.

---
 rtl/instr_mem_loader_pkg.sv | 30 +++
 rtl/instr_mem_loader_packer.sv | 31 +++
 rtl/instr_mem_loader.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants for the instruction-memory loader: MIPS opcodes, request
// class codes, loader FSM states and an I-type packing helper.
package loader_pkg;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [2:0] CLS_R   = 3'd0;
    localparam logic [2:0] CLS_LW  = 3'd1;
    localparam logic [2:0] CLS_SW  = 3'd2;
    localparam logic [2:0] CLS_BEQ = 3'd3;
    localparam logic [2:0] CLS_J   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [31:0] enc_itype(input logic [5:0]  op,
                                              input logic [4:0]  rs,
                                              input logic [4:0]  rt,
                                              input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_mem_loader_packer.sv
// Combinational packer: turns a symbolic request (class plus fields) into a
// 32-bit MIPS word and flags classes that have no encoding.
module instr_field_packer
    import loader_pkg::*;
(
    input  logic [2:0]  cls_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    // Select the instruction format from the request class.
    always_comb begin
        word_o  = 32'h0000_0000;
        legal_o = 1'b1;
        case (cls_i)
            CLS_R:   word_o = {OP_R, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            CLS_LW:  word_o = enc_itype(OP_LW, rs_i, rt_i, imm_i);
            CLS_SW:  word_o = enc_itype(OP_SW, rs_i, rt_i, imm_i);
            CLS_BEQ: word_o = enc_itype(OP_BEQ, rs_i, rt_i, imm_i);
            CLS_J:   word_o = {OP_J, target_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Sequential instruction-memory writer: accepts packed requests during a load
// session and issues one registered write per legal request at rising addresses.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        cls,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);

    state_e            state_q;
    logic [ADDR_W:0]   ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              done_q;
    logic              err_q;

    logic [31:0]       word_s;
    logic              legal_s;
    logic              full_s;
    logic              accept_s;

    instr_field_packer u_packer (
        .cls_i    (cls),
        .rs_i     (rs),
        .rt_i     (rt),
        .rd_i     (rd),
        .funct_i  (funct),
        .imm_i    (imm),
        .target_i (target),
        .word_o   (word_s),
        .legal_o  (legal_s)
    );

    // The pointer's top bit sets exactly when the last word address has been used.
    assign full_s   = ptr_q[ADDR_W];
    assign in_ready = (state_q == ST_LOAD) && !full_s;
    assign accept_s = in_valid && in_ready;

    // Session FSM, write pointer, word counter and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        ptr_q   <= BASE_PTR;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (start) begin
                        ptr_q   <= BASE_PTR;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end else if (accept_s) begin
                        if (legal_s) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q[ADDR_W-1:0];
                            wdata_q <= word_s;
                            ptr_q   <= ptr_q + ONE;
                            count_q <= count_q + ONE;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (in_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (in_valid && full_s) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign busy     = (state_q == ST_LOAD);
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;

endmodule
